// File: rtl/mips_hz_pkg.sv
// mips_hz_pkg: shared constants, forwarding encodings and stage record for the hazard unit
package mips_hz_pkg;

    localparam int TUSE_NONE = 3;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic       we;
    } stage_rec_t;

    // A record only produces register r when it writes, targets r, and r is not $0.
    function automatic logic hz_match(input logic we, input logic [4:0] a3, input logic [4:0] r);
        return we && (a3 == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// hz_stage_reg: async-reset pipeline record register with synchronous clear (bubble insert)
module hz_stage_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  T     d,
    output T     q
);

    // Record advances every edge; clr loads an all-zero bubble.
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else       q <= clr ? '0 : d;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall and forwarding control for a Tuse/Tnew five-stage MIPS pipeline
module hazard_unit
    import mips_hz_pkg::*;
#(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    D_rs,
    input  logic [4:0]    D_rt,
    input  logic [TW-1:0] D_Tuse_rs,
    input  logic [TW-1:0] D_Tuse_rt,
    input  logic [TW-1:0] D_Tnew,
    input  logic [4:0]    D_A3,
    input  logic          D_regwrite,
    output logic          stall,
    output logic          F_en,
    output logic          D_en,
    output logic          E_clr,
    output logic [1:0]    fwd_D_rs,
    output logic [1:0]    fwd_D_rt,
    output logic [1:0]    fwd_E_rs,
    output logic [1:0]    fwd_E_rt,
    output logic [1:0]    fwd_M_rt
);

    typedef struct packed {
        stage_rec_t    r;
        logic [TW-1:0] tnew;
    } e_rec_t;

    typedef struct packed {
        logic [4:0]    rt;
        logic [4:0]    a3;
        logic          we;
        logic [TW-1:0] tnew;
    } m_rec_t;

    typedef struct packed {
        logic [4:0] a3;
        logic       we;
    } w_rec_t;

    e_rec_t e, e_d;
    m_rec_t m, m_d;
    w_rec_t w, w_d;

    // Operand must wait while a matching producer in E or M is further from ready than the consumer can tolerate.
    function automatic logic hazard(input logic [4:0] r, input logic [TW-1:0] tuse, input e_rec_t er, input m_rec_t mr);
        return (tuse != TW'(TUSE_NONE)) &&
               ((hz_match(er.r.we, er.r.a3, r) && er.tnew > tuse) ||
                (hz_match(mr.we, mr.a3, r) && mr.tnew > tuse));
    endfunction

    function automatic logic [1:0] fwd_d(input logic [4:0] r, input e_rec_t er, input m_rec_t mr, input w_rec_t wr);
        return (hz_match(er.r.we, er.r.a3, r) && er.tnew == '0) ? FWD_E :
               (hz_match(mr.we, mr.a3, r) && mr.tnew == '0)     ? FWD_M :
               hz_match(wr.we, wr.a3, r)                         ? FWD_W : FWD_RF;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r, input m_rec_t mr, input w_rec_t wr);
        return (hz_match(mr.we, mr.a3, r) && mr.tnew == '0) ? FWD_M :
               hz_match(wr.we, wr.a3, r)                     ? FWD_W : FWD_RF;
    endfunction

    // Next-record values: D into E, E into M with one cycle less to ready (floored at 0), M into W.
    always_comb begin
        e_d.r    = '{rs: D_rs, rt: D_rt, a3: D_A3, we: D_regwrite};
        e_d.tnew = D_Tnew;
        m_d      = '{rt: e.r.rt, a3: e.r.a3, we: e.r.we, tnew: (e.tnew == '0) ? '0 : e.tnew - TW'(1)};
        w_d      = '{a3: m.a3, we: m.we};
    end

    hz_stage_reg #(.T(e_rec_t)) u_e (.clk(clk), .reset(reset), .clr(stall), .d(e_d), .q(e));
    hz_stage_reg #(.T(m_rec_t)) u_m (.clk(clk), .reset(reset), .clr(1'b0),  .d(m_d), .q(m));
    hz_stage_reg #(.T(w_rec_t)) u_w (.clk(clk), .reset(reset), .clr(1'b0),  .d(w_d), .q(w));

    // Stall, enables and forwarding selects are purely combinational from records and D inputs.
    always_comb begin
        stall    = hazard(D_rs, D_Tuse_rs, e, m) || hazard(D_rt, D_Tuse_rt, e, m);
        F_en     = ~stall;
        D_en     = ~stall;
        E_clr    = stall;
        fwd_D_rs = fwd_d(D_rs, e, m, w);
        fwd_D_rt = fwd_d(D_rt, e, m, w);
        fwd_E_rs = fwd_e(e.r.rs, m, w);
        fwd_E_rt = fwd_e(e.r.rt, m, w);
        fwd_M_rt = hz_match(w.we, w.a3, m.rt) ? FWD_W : FWD_RF;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       D_regwrite;
    logic       stall, F_en, D_en, E_clr;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;
    int         n_pass = 0;
    int         n_tot = 0;

    hazard_unit #(.TW(2)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_Tnew(D_Tnew), .D_A3(D_A3), .D_regwrite(D_regwrite),
        .stall(stall), .F_en(F_en), .D_en(D_en), .E_clr(E_clr),
        .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt), .fwd_E_rs(fwd_E_rs),
        .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_ctl(input string tag, input logic s);
        chk({tag, ".stall"}, {1'b0, stall}, {1'b0, s});
        chk({tag, ".F_en"},  {1'b0, F_en},  {1'b0, ~s});
        chk({tag, ".D_en"},  {1'b0, D_en},  {1'b0, ~s});
        chk({tag, ".E_clr"}, {1'b0, E_clr}, {1'b0, s});
    endtask

    task automatic chk_fwd0(input string tag);
        chk({tag, ".fDrs"}, fwd_D_rs, 2'd0);
        chk({tag, ".fDrt"}, fwd_D_rt, 2'd0);
        chk({tag, ".fErs"}, fwd_E_rs, 2'd0);
        chk({tag, ".fErt"}, fwd_E_rt, 2'd0);
        chk({tag, ".fMrt"}, fwd_M_rt, 2'd0);
    endtask

    task automatic setd(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] urs,
                        input logic [1:0] urt, input logic [1:0] tn, input logic [4:0] a3, input logic we);
        D_rs = rs; D_rt = rt; D_Tuse_rs = urs; D_Tuse_rt = urt; D_Tnew = tn; D_A3 = a3; D_regwrite = we;
    endtask

    task automatic nop();
        setd(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string tag);
        nop();
        #1 reset = 1'b1;
        #1;
        chk_ctl(tag, 1'b0);
        chk_fwd0(tag);
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        nop();
        do_reset("rst");

        // lw $8 ; addu uses $8 as rs with Tuse 1 -> one stall cycle
        setd(5'd29, 5'd8, 2'd1, 2'd3, 2'd2, 5'd8, 1'b1);
        #1 chk_ctl("lw_addu.c0", 1'b0);
        tick();
        setd(5'd8, 5'd10, 2'd1, 2'd1, 2'd1, 5'd11, 1'b1);
        #1 chk_ctl("lw_addu.c1", 1'b1);
        tick();
        chk_ctl("lw_addu.c2", 1'b0);
        chk("lw_addu.fDrs", fwd_D_rs, 2'd0);
        tick();
        nop();
        #1 chk("lw_addu.fErs", fwd_E_rs, 2'd3);

        do_reset("rst2");
        // lw $8 ; beq $8 with Tuse 0 -> two stall cycles, then W forward
        setd(5'd29, 5'd8, 2'd1, 2'd3, 2'd2, 5'd8, 1'b1);
        tick();
        setd(5'd8, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        #1 chk_ctl("lw_beq.c1", 1'b1);
        tick();
        chk_ctl("lw_beq.c2", 1'b1);
        tick();
        chk_ctl("lw_beq.c3", 1'b0);
        chk("lw_beq.fDrs", fwd_D_rs, 2'd3);

        do_reset("rst3");
        // addu $9 ; sw with rt=$9 Tuse 2 -> no stall, E then M forwarding of store data
        setd(5'd1, 5'd2, 2'd1, 2'd1, 2'd1, 5'd9, 1'b1);
        tick();
        setd(5'd29, 5'd9, 2'd1, 2'd2, 2'd0, 5'd0, 1'b0);
        #1 chk_ctl("addu_sw.c1", 1'b0);
        chk("addu_sw.fDrt", fwd_D_rt, 2'd0);
        tick();
        nop();
        #1 chk("addu_sw.fErt", fwd_E_rt, 2'd2);
        tick();
        chk("addu_sw.fMrt", fwd_M_rt, 2'd3);

        do_reset("rst4");
        // jal ; jr $31 -> forwarded from E without stalling
        setd(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd31, 1'b1);
        tick();
        setd(5'd31, 5'd0, 2'd0, 2'd3, 2'd0, 5'd0, 1'b0);
        #1 chk_ctl("jal_jr", 1'b0);
        chk("jal_jr.fDrs", fwd_D_rs, 2'd1);

        do_reset("rst5");
        // Writer of $0 never creates a hazard or a forward
        setd(5'd0, 5'd0, 2'd3, 2'd3, 2'd2, 5'd0, 1'b1);
        tick();
        setd(5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        #1 chk_ctl("r0", 1'b0);
        chk_fwd0("r0");
        // Tuse 3 operands never stall even against a pending load
        setd(5'd29, 5'd8, 2'd1, 2'd3, 2'd2, 5'd8, 1'b1);
        tick();
        setd(5'd8, 5'd8, 2'd3, 2'd3, 2'd0, 5'd0, 1'b0);
        #1 chk_ctl("tuse3.c1", 1'b0);
        chk("tuse3.fDrs", fwd_D_rs, 2'd0);
        tick();
        nop();
        #1 chk_ctl("tuse3.c2", 1'b0);
        chk("tuse3.fErs", fwd_E_rs, 2'd0);

        do_reset("rst6");
        // E, M and W all write $5 with ready results: youngest (E) wins
        setd(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd5, 1'b1);
        tick();
        tick();
        tick();
        setd(5'd5, 5'd5, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        #1 chk_ctl("prio", 1'b0);
        chk("prio.fDrs", fwd_D_rs, 2'd1);
        chk("prio.fDrt", fwd_D_rt, 2'd1);

        do_reset("rst7");
        // Reset asserted mid-stall clears the records without a clock edge
        setd(5'd29, 5'd8, 2'd1, 2'd3, 2'd2, 5'd8, 1'b1);
        tick();
        setd(5'd8, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        #1 chk_ctl("midrst.pre", 1'b1);
        reset = 1'b1;
        #1 chk_ctl("midrst.in", 1'b0);
        chk_fwd0("midrst.in");
        #2 reset = 1'b0;
        #1 chk_ctl("midrst.rel", 1'b0);
        tick();
        chk_ctl("midrst.post", 1'b0);
        chk_fwd0("midrst.post");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
